mem_req_arbiter: RTL and testbench

//  Two-client arbiter sharing one MemIO port (req_cmd / req_data / resp) between the tag cache
//  and a second requester (e.g. uncached/IO path) ahead of the memory controller.

---
 rtl/mem_req_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-client MemIO arbiter: round-robin command grant, write-burst data lock,
// client id prepended to the memory tag and used to route responses back.
module mem_req_arbiter #(
  parameter int ADDR_W     = 26,
  parameter int TAG_W      = 5,
  parameter int DATA_W     = 128,
  parameter int DATA_BEATS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_cmd_valid,
  output logic              c0_cmd_ready,
  input  logic [ADDR_W-1:0] c0_cmd_addr,
  input  logic [TAG_W-1:0]  c0_cmd_tag,
  input  logic              c0_cmd_rw,
  input  logic              c0_data_valid,
  output logic              c0_data_ready,
  input  logic [DATA_W-1:0] c0_data_data,
  output logic              c0_resp_valid,
  output logic [DATA_W-1:0] c0_resp_data,
  output logic [TAG_W-1:0]  c0_resp_tag,
  input  logic              c1_cmd_valid,
  output logic              c1_cmd_ready,
  input  logic [ADDR_W-1:0] c1_cmd_addr,
  input  logic [TAG_W-1:0]  c1_cmd_tag,
  input  logic              c1_cmd_rw,
  input  logic              c1_data_valid,
  output logic              c1_data_ready,
  input  logic [DATA_W-1:0] c1_data_data,
  output logic              c1_resp_valid,
  output logic [DATA_W-1:0] c1_resp_data,
  output logic [TAG_W-1:0]  c1_resp_tag,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [TAG_W:0]    mem_cmd_tag,
  output logic              mem_cmd_rw,
  output logic              mem_data_valid,
  input  logic              mem_data_ready,
  output logic [DATA_W-1:0] mem_data_data,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic [TAG_W:0]    mem_resp_tag
);

  localparam int BEAT_W = $clog2(DATA_BEATS) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WDATA
  } state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              prio_q, prio_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              sel_cmd_valid;
  logic              sel_cmd_rw;
  logic [ADDR_W-1:0] sel_cmd_addr;
  logic [TAG_W-1:0]  sel_cmd_tag;
  logic              sel_data_valid;
  logic [DATA_W-1:0] sel_data_data;
  logic              cmd_rdy;
  logic              data_rdy;
  logic              data_fire;

  always_comb begin
    sel_cmd_valid  = gnt_q ? c1_cmd_valid  : c0_cmd_valid;
    sel_cmd_rw     = gnt_q ? c1_cmd_rw     : c0_cmd_rw;
    sel_cmd_addr   = gnt_q ? c1_cmd_addr   : c0_cmd_addr;
    sel_cmd_tag    = gnt_q ? c1_cmd_tag    : c0_cmd_tag;
    sel_data_valid = gnt_q ? c1_data_valid : c0_data_valid;
    sel_data_data  = gnt_q ? c1_data_data  : c0_data_data;
  end

  assign mem_cmd_addr  = sel_cmd_addr;
  assign mem_cmd_tag   = {gnt_q, sel_cmd_tag};
  assign mem_cmd_rw    = sel_cmd_rw;
  assign mem_data_data = sel_data_data;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    prio_d         = prio_q;
    beat_d         = beat_q;
    mem_cmd_valid  = 1'b0;
    mem_data_valid = 1'b0;
    cmd_rdy        = 1'b0;
    data_rdy       = 1'b0;
    data_fire      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c0_cmd_valid || c1_cmd_valid) begin
          state_d = GRANT;
          gnt_d   = (c0_cmd_valid && c1_cmd_valid) ? prio_q : c1_cmd_valid;
        end
      end
      GRANT: begin
        mem_cmd_valid = sel_cmd_valid;
        cmd_rdy       = mem_cmd_ready;
        // A requester that drops valid loses the grant without a prio flip
        if (!sel_cmd_valid) begin
          state_d = IDLE;
        end else if (mem_cmd_ready) begin
          prio_d = ~gnt_q;
          if (sel_cmd_rw) begin
            state_d = WDATA;
            beat_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WDATA: begin
        mem_data_valid = sel_data_valid;
        data_rdy       = mem_data_ready;
        data_fire      = sel_data_valid && mem_data_ready;
        if (data_fire) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign c0_cmd_ready  = cmd_rdy  & ~gnt_q;
  assign c1_cmd_ready  = cmd_rdy  &  gnt_q;
  assign c0_data_ready = data_rdy & ~gnt_q;
  assign c1_data_ready = data_rdy &  gnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      beat_q  <= beat_d;
    end
  end

  assign c0_resp_valid = mem_resp_valid & ~mem_resp_tag[TAG_W];
  assign c1_resp_valid = mem_resp_valid &  mem_resp_tag[TAG_W];
  assign c0_resp_data  = mem_resp_data;
  assign c1_resp_data  = mem_resp_data;
  assign c0_resp_tag   = mem_resp_tag[TAG_W-1:0];
  assign c1_resp_tag   = mem_resp_tag[TAG_W-1:0];

`ifndef SYNTHESIS
  a_cmd_stable: assert property (@(posedge clk) disable iff (!reset)
    (mem_cmd_valid && !mem_cmd_ready) |=>
      (mem_cmd_valid && $stable(mem_cmd_addr) &&
       $stable(mem_cmd_tag) && $stable(mem_cmd_rw)));

  a_one_cmd_ready: assert property (@(posedge clk) disable iff (!reset)
    !(c0_cmd_ready && c1_cmd_ready));

  a_data_in_wdata: assert property (@(posedge clk) disable iff (!reset)
    (mem_data_valid && mem_data_ready) |-> (state_q == WDATA));
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: command, data and response queues
// filled by the stimulus and drained by a negedge monitor.
module tb_mem_req_arbiter;
  localparam int A  = 26;
  localparam int T  = 5;
  localparam int D  = 128;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         cv[2], cr[2], crw[2], dv[2], dr[2], rv[2];
  logic [A-1:0] ca[2];
  logic [T-1:0] ct[2], rt[2];
  logic [D-1:0] dd[2], rd[2];
  logic         mcv, mcr, mrw, mdv, mdr, mrv;
  logic [A-1:0] maddr;
  logic [T:0]   mtag, mrt;
  logic [D-1:0] mdd, mrd;

  mem_req_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_cmd_valid(cv[0]), .c0_cmd_ready(cr[0]), .c0_cmd_addr(ca[0]),
    .c0_cmd_tag(ct[0]), .c0_cmd_rw(crw[0]),
    .c0_data_valid(dv[0]), .c0_data_ready(dr[0]), .c0_data_data(dd[0]),
    .c0_resp_valid(rv[0]), .c0_resp_data(rd[0]), .c0_resp_tag(rt[0]),
    .c1_cmd_valid(cv[1]), .c1_cmd_ready(cr[1]), .c1_cmd_addr(ca[1]),
    .c1_cmd_tag(ct[1]), .c1_cmd_rw(crw[1]),
    .c1_data_valid(dv[1]), .c1_data_ready(dr[1]), .c1_data_data(dd[1]),
    .c1_resp_valid(rv[1]), .c1_resp_data(rd[1]), .c1_resp_tag(rt[1]),
    .mem_cmd_valid(mcv), .mem_cmd_ready(mcr), .mem_cmd_addr(maddr),
    .mem_cmd_tag(mtag), .mem_cmd_rw(mrw),
    .mem_data_valid(mdv), .mem_data_ready(mdr), .mem_data_data(mdd),
    .mem_resp_valid(mrv), .mem_resp_data(mrd), .mem_resp_tag(mrt)
  );

  typedef struct packed {
    logic [T:0]   tag;
    logic [A-1:0] addr;
    logic         rw;
  } cmd_t;

  typedef struct packed {
    logic         cl;
    logic [T-1:0] tag;
    logic [D-1:0] data;
  } rsp_t;

  cmd_t         exp_cmd[$];
  logic [D-1:0] exp_dat[$];
  rsp_t         exp_rsp[$];

  int checks = 0;
  int errors = 0;
  int fires  = 0;
  int pend   = 0;
  int owner  = 0;

  task automatic chk(input string tg, input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory-side monitor
  initial begin
    cmd_t c;
    rsp_t r;
    logic [D-1:0] x;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 0;
      end else begin
        if (mcv && mcr) begin
          fires++;
          chk("cmd_in_burst", pend, 0);
          if (exp_cmd.size() == 0) begin
            chk("cmd_unexpected", mtag, '1);
          end else begin
            c = exp_cmd.pop_front();
            chk("cmd_tag", mtag, c.tag);
            chk("cmd_addr", maddr, c.addr);
            chk("cmd_rw", mrw, c.rw);
            if (c.rw) begin
              pend  = NB;
              owner = int'(c.tag[T]);
            end
          end
        end
        if (mdv && mdr) begin
          chk("data_pend", pend > 0, 1);
          chk("other_rdy", {dr[1-owner], cr[1-owner]}, 0);
          pend--;
          if (exp_dat.size() == 0) begin
            chk("data_unexpected", mdd, '1);
          end else begin
            x = exp_dat.pop_front();
            chk("data_beat", mdd, x);
          end
        end
        if (mrv) begin
          if (exp_rsp.size() == 0) begin
            chk("rsp_unexpected", mrt, '1);
          end else begin
            r = exp_rsp.pop_front();
            chk("rsp_valid", {rv[1], rv[0]}, r.cl ? 2'b10 : 2'b01);
            chk("rsp_tag", rt[r.cl], r.tag);
            chk("rsp_data", rd[r.cl], r.data);
          end
        end
      end
    end
  end

  task automatic send_cmd(input int n, input logic [A-1:0] a,
                          input logic [T-1:0] t, input logic w);
    bit done;
    done  = 1'b0;
    cv[n] = 1'b1;
    ca[n] = a;
    ct[n] = t;
    crw[n] = w;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = cr[n];
      @(posedge clk);
      #1;
    end
    cv[n] = 1'b0;
    if (!done) chk("cmd_timeout", 0, 1);
  endtask

  task automatic send_beat(input int n, input logic [D-1:0] v);
    bit done;
    done  = 1'b0;
    dv[n] = 1'b1;
    dd[n] = v;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = dr[n];
      @(posedge clk);
      #1;
    end
    if (!done) chk("data_timeout", 0, 1);
  endtask

  task automatic send_data(input int n, input logic [D-1:0] base);
    for (int b = 0; b < NB; b++) send_beat(n, base + D'(b));
    dv[n] = 1'b0;
  endtask

  task automatic send_resp(input logic cl, input logic [T-1:0] t,
                           input logic [D-1:0] v);
    rsp_t r;
    r.cl = cl;
    r.tag = t;
    r.data = v;
    exp_rsp.push_back(r);
    mrv = 1'b1;
    mrt = {cl, t};
    mrd = v;
    step(1);
    mrv = 1'b0;
  endtask

  function automatic cmd_t mk(input logic id, input logic [T-1:0] t,
                              input logic [A-1:0] a, input logic w);
    cmd_t c;
    c.tag  = {id, t};
    c.addr = a;
    c.rw   = w;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs;
    for (int n = 0; n < 2; n++) begin
      cv[n] = 0; ca[n] = '0; ct[n] = '0; crw[n] = 0;
      dv[n] = 0; dd[n] = '0;
    end
    mcr = 1'b1; mdr = 1'b1; mrv = 1'b0; mrt = '0; mrd = '0;
    step(2);
    chk("rst_valid", {mcv, mdv}, 0);
    chk("rst_ready", {cr[0], cr[1], dr[0], dr[1]}, 0);
    reset = 1'b1;
    step(1);

    // both clients request together after reset: c0 first
    exp_cmd.push_back(mk(0, 5'd2, 26'h40, 0));
    exp_cmd.push_back(mk(1, 5'd7, 26'h80, 0));
    fork
      send_cmd(0, 26'h40, 5'd2, 0);
      send_cmd(1, 26'h80, 5'd7, 0);
    join
    send_resp(1, 5'd7, 128'h1234);
    step(2);

    // single read: one-cycle grant latency, response routed to c0
    exp_cmd.push_back(mk(0, 5'd3, 26'h100, 0));
    fork
      send_cmd(0, 26'h100, 5'd3, 0);
      begin
        @(negedge clk);
        chk("t1_lat0", mcv, 0);
        @(negedge clk);
        chk("t1_lat1", mcv, 1);
        chk("t1_tag", mtag, 6'h03);
      end
    join
    send_resp(0, 5'd3, {16{8'hA5}});
    step(2);

    // c1 write burst; c0 read waits for the last beat
    exp_cmd.push_back(mk(1, 5'd4, 26'h200, 1));
    for (int b = 0; b < NB; b++) exp_dat.push_back(128'hD0 + D'(b));
    exp_cmd.push_back(mk(0, 5'd5, 26'h300, 0));
    fork
      begin
        send_cmd(1, 26'h200, 5'd4, 1);
        send_data(1, 128'hD0);
      end
      begin
        step(2);
        send_cmd(0, 26'h300, 5'd5, 0);
      end
    join
    step(2);

    // memory stalls the command for five cycles
    mcr = 1'b0;
    exp_cmd.push_back(mk(0, 5'd9, 26'h2AB, 0));
    fork
      send_cmd(0, 26'h2AB, 5'd9, 0);
      begin
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_valid", mcv, 1);
          chk("stall_fields", {mtag, maddr, mrw}, {6'h09, 26'h2AB, 1'b0});
          chk("stall_rdy", cr[0], 0);
        end
        step(1);
        mcr = 1'b1;
      end
    join
    step(2);

    // reset in the middle of a write burst
    exp_cmd.push_back(mk(1, 5'd1, 26'h44, 1));
    exp_dat.push_back(128'hE0);
    exp_dat.push_back(128'hE1);
    send_cmd(1, 26'h44, 5'd1, 1);
    send_beat(1, 128'hE0);
    send_beat(1, 128'hE1);
    dd[1] = 128'hE2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", {mcv, mdv}, 0);
    chk("midrst_ready", {cr[0], cr[1], dr[0], dr[1]}, 0);
    chk("midrst_q", exp_dat.size(), 0);
    dv[1] = 1'b0;
    exp_cmd.push_back(mk(0, 5'd8, 26'h66, 0));
    exp_cmd.push_back(mk(1, 5'd6, 26'h55, 0));
    fork
      send_cmd(1, 26'h55, 5'd6, 0);
      begin
        step(1);
        send_cmd(0, 26'h66, 5'd8, 0);
      end
      begin
        step(3);
        reset = 1'b1;
      end
    join
    step(2);

    // two full-rate read streams alternate grants
    for (int i = 0; i < 8; i++) begin
      exp_cmd.push_back(mk(0, T'(i), A'(32'h1000 + i), 0));
      exp_cmd.push_back(mk(1, T'(i + 8), A'(32'h2000 + i), 0));
    end
    fs = fires;
    fork
      for (int i = 0; i < 8; i++) send_cmd(0, A'(32'h1000 + i), T'(i), 0);
      for (int i = 0; i < 8; i++) send_cmd(1, A'(32'h2000 + i), T'(i + 8), 0);
      begin
        repeat (32) @(negedge clk);
        #1;
        chk("stream_rate", fires - fs, 16);
      end
    join
    step(4);

    chk("cmd_q_empty", exp_cmd.size(), 0);
    chk("dat_q_empty", exp_dat.size(), 0);
    chk("rsp_q_empty", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
